// File: rtl/alu8_pkg.sv
// Shared definitions for the byte-wide ALU and its multi-byte sequencer.
// Op code layout is {k, i, j, c_in}: k selects arithmetic, i/j shape operand B.
// Flag vectors are ordered {C, Z, V, N} from bit 3 down to bit 0.
package alu8_pkg;

    // Op code bit positions
    localparam int OPB_K   = 3;
    localparam int OPB_I   = 2;
    localparam int OPB_J   = 1;
    localparam int OPB_CIN = 0;

    // Canonical op codes
    localparam logic [3:0] OP_ADD = 4'b1100;
    localparam logic [3:0] OP_SUB = 4'b1111;
    localparam logic [3:0] OP_INC = 4'b1001;
    localparam logic [3:0] OP_DEC = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0010;

    // Flag bit indices within rsp_flg
    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu8.sv
// Byte-wide combinational ALU: arithmetic a + ((b & i) ^ j) + c_in, or a logic op.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller owns all sequencing.
module alu8
    import alu8_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] res,
    output logic       c_out
);

    logic [7:0] bx;
    logic [8:0] sum;

    // Shape B, add with carry, or pick a logic function when k is clear
    always_comb begin
        bx    = (b & {8{op[OPB_I]}}) ^ {8{op[OPB_J]}};
        sum   = {1'b0, a} + {1'b0, bx} + {8'b0, op[OPB_CIN]};
        res   = 8'h00;
        c_out = 1'b0;
        if (op[OPB_K]) begin
            res   = sum[7:0];
            c_out = sum[8];
        end else begin
            case ({op[OPB_I], op[OPB_J]})
                2'b00:   res = a & b;
                2'b10:   res = a | b;
                2'b01:   res = a ^ b;
                default: res = ~(a ^ b);
            endcase
        end
    end

endmodule

// File: rtl/alu8_seq.sv
// Byte-serial W-bit ALU: one alu8 driven LSB-first over NBYTES cycles, carry chained in a register.
// Latency: rsp_valid rises NBYTES edges after the command is accepted.
// Backpressure: result and flags hold in DONE until rsp_ready; commands are refused until back in IDLE.
module alu8_seq
    import alu8_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [8*NBYTES-1:0]   cmd_a,
    input  logic [8*NBYTES-1:0]   cmd_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_res,
    output logic [3:0]            rsp_flg
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    state_t         state;
    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [IW-1:0]  idx;
    logic           carry;
    logic           zacc;

    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic [7:0]     alu_res;
    logic           alu_cin;
    logic           alu_cout;
    logic           zbyte;
    logic           last;
    logic           bx_msb;

    // Only IDLE takes commands, and never while reset is asserted
    assign cmd_ready = (state == ST_IDLE) && !rst;

    // Select the current byte lane and the carry feeding it
    always_comb begin
        alu_a   = a_q[{idx, 3'b000} +: 8];
        alu_b   = b_q[{idx, 3'b000} +: 8];
        alu_cin = (idx == '0) ? op_q[OPB_CIN] : carry;
        zbyte   = (alu_res == 8'h00);
        last    = (idx == IW'(NBYTES - 1));
        bx_msb  = (b_q[W-1] & op_q[OPB_I]) ^ op_q[OPB_J];
    end

    alu8 u_alu8 (
        .a     (alu_a),
        .b     (alu_b),
        .op    ({op_q[OPB_K:OPB_J], alu_cin}),
        .res   (alu_res),
        .c_out (alu_cout)
    );

    // Sequencer: capture in IDLE, one byte per RUN cycle, hold result in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            zacc      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_flg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        idx     <= '0;
                        carry   <= 1'b0;
                        zacc    <= 1'b1;
                        rsp_res <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rsp_res[{idx, 3'b000} +: 8] <= alu_res;
                    carry <= alu_cout;
                    zacc  <= zacc & zbyte;
                    if (last) begin
                        // Flags come from the whole-word result; the top byte is in flight here
                        rsp_flg[FLG_C] <= op_q[OPB_K] & alu_cout;
                        rsp_flg[FLG_Z] <= zacc & zbyte;
                        rsp_flg[FLG_V] <= op_q[OPB_K] & (a_q[W-1] == bx_msb)
                                          & (alu_res[7] != a_q[W-1]);
                        rsp_flg[FLG_N] <= alu_res[7];
                        rsp_valid      <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu8_seq.sv
// Self-checking bench for alu8_seq at NBYTES=4: directed cases plus random ops vs a word-level model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Result is one summary line with error and check counts.
module tb_alu8_seq;
    import alu8_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_res;
    logic [3:0]   rsp_flg;

    int errs   = 0;
    int checks = 0;

    logic [W-1:0] m_res;
    logic [3:0]   m_flg;
    logic [W-1:0] held_a;

    always #5 clk = ~clk;

    alu8_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_flg   (rsp_flg)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: arithmetic on 33 bits, flags from the finished word
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] f);
        logic [W-1:0] bx;
        logic [W:0]   sum;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        bx = (op[2] ? b : '0) ^ (op[1] ? '1 : '0);
        if (op[3]) begin
            sum = {1'b0, a} + {1'b0, bx} + W'(op[0]);
            r   = sum[W-1:0];
            c   = sum[W];
            v   = (a[W-1] == bx[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            if (op == OP_AND)      r = a & b;
            else if (op == OP_OR)  r = a | b;
            else if (op == OP_XOR) r = a ^ b;
            else                   r = ~(a ^ b);
        end
        f = {c, (r == '0), v, r[W-1]};
    endfunction

    // Present a command at a falling edge and let the next rising edge accept it
    task automatic accept_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called at the falling edge right after acceptance; checks latency, hold under stall, handshake
    task automatic finish_rsp(input string tag, input logic [W-1:0] er, input logic [3:0] ef,
                              input int stall, input bit hold_cmd);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        chk({tag, "_res"}, 64'(rsp_res), 64'(er));
        chk({tag, "_flg"}, 64'(rsp_flg), 64'(ef));
        for (int s = 0; s < stall; s++) begin
            if (hold_cmd) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_AND;
                cmd_a     = $urandom;
                cmd_b     = 32'hFFFF_0000;
                held_a    = cmd_a;
            end
            @(negedge clk);
            chk({tag, "_stall_vld"}, 64'(rsp_valid), 64'd1);
            chk({tag, "_stall_rdy"}, 64'(cmd_ready), 64'd0);
            chk({tag, "_stall_res"}, 64'(rsp_res), 64'(er));
            chk({tag, "_stall_flg"}, 64'(rsp_flg), 64'(ef));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_vld_drop"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_idle_rdy"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        logic [3:0] ops [7];
        logic [3:0] op;
        logic [W-1:0] a, b;
        bit ok;
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_INC; ops[3] = OP_DEC;
        ops[4] = OP_AND; ops[5] = OP_OR;  ops[6] = OP_XOR;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        rsp_ready = 1'b0;
        held_a = '0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_res", 64'(rsp_res), 64'd0);
        chk("rst_rsp_flg", 64'(rsp_flg), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);

        // Directed corner cases
        accept_cmd(OP_ADD, 32'h0000_00FF, 32'h0000_0001);
        finish_rsp("add_carry", 32'h0000_0100, 4'b0000, 0, 1'b0);
        accept_cmd(OP_SUB, 32'h0000_0000, 32'h0000_0001);
        finish_rsp("sub_borrow", 32'hFFFF_FFFF, 4'b0001, 0, 1'b0);
        accept_cmd(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        finish_rsp("add_ovf", 32'h8000_0000, 4'b0011, 1, 1'b0);
        accept_cmd(OP_INC, 32'hFFFF_FFFF, 32'h0000_0000);
        finish_rsp("inc_wrap", 32'h0000_0000, 4'b1100, 0, 1'b0);
        accept_cmd(OP_SUB, 32'h1234_5678, 32'h1234_5678);
        finish_rsp("sub_eq", 32'h0000_0000, 4'b1100, 0, 1'b0);
        accept_cmd(OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        finish_rsp("xor_zero", 32'h0000_0000, 4'b0100, 0, 1'b0);
        accept_cmd(OP_DEC, 32'h0000_0000, 32'h0000_0000);
        finish_rsp("dec_wrap", 32'hFFFF_FFFF, 4'b0001, 0, 1'b0);

        // Backpressure with a competing command held on the input
        accept_cmd(OP_ADD, 32'h1111_1111, 32'h2222_2222);
        finish_rsp("bp", 32'h3333_3333, 4'b0000, 3, 1'b1);
        chk("bp_cmd_still_valid", 64'(cmd_valid), 64'd1);
        model(OP_AND, held_a, 32'hFFFF_0000, m_res, m_flg);
        accept_cmd(OP_AND, held_a, 32'hFFFF_0000);
        finish_rsp("bp_next", m_res, m_flg, 0, 1'b0);

        // Reset in the middle of an operation
        accept_cmd(OP_ADD, 32'hDEAD_BEEF, 32'h0101_0101);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
        chk("mid_rst_vld", 64'(rsp_valid), 64'd0);
        chk("mid_rst_res", 64'(rsp_res), 64'd0);
        chk("mid_rst_flg", 64'(rsp_flg), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_release_ready", 64'(cmd_ready), 64'd1);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
        end
        chk("mid_rst_quiet", 64'(ok), 64'd1);
        accept_cmd(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        finish_rsp("and_after_rst", 32'hF000_F000, 4'b0001, 0, 1'b0);

        // Random operations against the word-level model
        for (int t = 0; t < 40; t++) begin
            op = ops[$urandom_range(0, 6)];
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 32'h7FFF_FFFF;
                default: b = $urandom;
            endcase
            model(op, a, b, m_res, m_flg);
            accept_cmd(op, a, b);
            finish_rsp($sformatf("rnd%0d_op%0h", t, op), m_res, m_flg, $urandom_range(0, 2), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu8_seq.md
Name: alu8_seq

Overview:
- Byte-serial multi-byte ALU sequencer. Executes one NBYTES-wide operation by driving a single alu8 instance over NBYTES cycles, least significant byte first.
- Carry chains between bytes through an internal register, so one 8-bit datapath serves 16/32-bit add/sub/inc/dec and logic ops.
- Sits between an instruction/command source (valid/ready) and a result consumer (valid/ready).

Parameters:
- NBYTES, 4, number of bytes per operand (>=2); operand width W = 8*NBYTES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  4  alu8 op code {k,i,j,c_in}.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_res  out  W  result.
- rsp_flg  out  4  {C,Z,V,N}, bit3..bit0.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values: state IDLE, rsp_valid=0, rsp_res=0, rsp_flg=0, byte index=0, carry register=0. cmd_ready=0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at an edge: capture op, A and B; set idx=0; clear result register; set zacc=1; go to RUN.
- RUN (one byte per cycle):
  - cmd_ready=0.
  - alu8 inputs: a=A[idx], b=B[idx], op={k,i,j,cin}.
  - cin = op.c_in when idx=0. For idx>0, cin = carry register.
  - At each edge:
    - res[idx] <= alu8 res; carry <= alu8 c_out; zacc <= zacc & (res byte == 0).
    - If idx==NBYTES-1, go to DONE; otherwise idx <= idx+1.
- Flags, latched on the final RUN edge:
  - N = res[W-1].
  - Z = zacc including the final byte. Z is computed from the result, so it is valid for logic ops.
  - C = final c_out when k=1; 0 when k=0.
  - V, when k=1: (A[W-1] == bx) && (res[W-1] != A[W-1]), where bx = (B[W-1] & i) ^ j. V=0 when k=0.
  - The alu8 z/v/n flag outputs are not used.
- DONE:
  - rsp_valid=1. rsp_res and rsp_flg are held stable until rsp_ready.
  - At the edge where rsp_ready is high: rsp_valid <= 0, go to IDLE.
  - No command is accepted in DONE.
- Latency: rsp_valid rises NBYTES edges after the accepting edge. Minimum command spacing is NBYTES+2 cycles.
- cmd_* inputs are ignored outside IDLE; the operands are taken from the captured registers.
- Reset mid-operation: the operation is abandoned and no response is produced. After rst drops, the block is in IDLE with cmd_ready=1.
- All arithmetic wraps modulo 2^W. Subtraction C=1 means no borrow.

Decomposition:
- Shared package alu8_pkg:
  - op constants: OP_ADD=4'b1100, OP_SUB=4'b1111, OP_INC=4'b1001, OP_DEC=4'b0010+k → 4'b1010, OP_AND=4'b0000, OP_OR=4'b0100, OP_XOR=4'b0010.
  - flag bit indices: FLG_C=3, FLG_Z=2, FLG_V=1, FLG_N=0.
  - FSM state enum.
- Sub-modules: one instance of the existing alu8 datapath. No new sub-module. Byte select and byte write are plain indexed part-selects.

Test Plan (NBYTES=4):
- ADD 0x000000FF + 0x00000001 → res 0x00000100, flg 4'b0000; rsp_valid exactly 4 edges after accept.
- SUB 0x00000000 - 0x00000001 → res 0xFFFFFFFF, C=0, Z=0, V=0, N=1.
- ADD 0x7FFFFFFF + 0x00000001 → res 0x80000000, C=0, Z=0, V=1, N=1. Also INC 0xFFFFFFFF → res 0x00000000, C=1, Z=1.
- SUB 0x12345678 - 0x12345678 → res 0, C=1, Z=1, V=0, N=0. XOR 0xA5A5A5A5 ^ 0xA5A5A5A5 → res 0, flg 4'b0100.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 3 cycles in DONE, with cmd_valid=1 and changing cmd_a.
  - Required: rsp_res/rsp_flg stable, cmd_ready=0, and the new command is accepted only after rsp handshake plus return to IDLE.
- Reset mid-op:
  - Stimulus: pulse rst after 2 RUN cycles of ADD.
  - Required: rsp_valid stays 0, outputs 0, cmd_ready=1 after release; the next AND 0xF0F0F0F0 & 0xFF00FF00 gives res 0xF000F000, flg 4'b0001.
